// File: rtl/baud_tick_frac.sv
// Fractional baud-tick generator: a phase accumulator drives the oversample, mid-bit and end-of-bit ticks.
// The increment can be reprogrammed at runtime and is swapped in only on a bit boundary, resync or disable.
module baud_tick_frac #(
  parameter int unsigned     CLK_HZ      = 100_000_000,
  parameter int unsigned     BAUD        = 115_200,
  parameter int unsigned     OVERSAMPLE  = 8,
  parameter int unsigned     ACC_W       = 24,
  parameter longint unsigned DEFAULT_INC =
    (((64'(BAUD) * 64'(OVERSAMPLE)) << ACC_W) * 64'd2 + 64'(CLK_HZ)) / (64'(CLK_HZ) * 64'd2)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             resync_in,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_load_in,
  output logic             pending_out,
  output logic             os_tick_out,
  output logic             mid_tick_out,
  output logic             bit_tick_out
);

  localparam int unsigned     CNT_W    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [ACC_W-1:0] INC_RST  = ACC_W'(DEFAULT_INC);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             os_q, os_d;
  logic             mid_q, mid_d;
  logic             bit_q, bit_d;

  logic [ACC_W:0]   sum_c;
  logic             carry_c;
  logic             bnd_c;
  logic             apply_c;

  assign sum_c   = {1'b0, acc_q} + {1'b0, inc_q};
  assign carry_c = sum_c[ACC_W];

  // Next-state: phase advance, tick decode and increment hand-over.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    inc_d      = inc_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    os_d       = 1'b0;
    mid_d      = 1'b0;
    bit_d      = 1'b0;
    bnd_c      = 1'b0;

    if (resync_in) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en_in) begin
      acc_d = sum_c[ACC_W-1:0];
      if (carry_c) begin
        os_d  = 1'b1;
        mid_d = (cnt_q == CNT_MID);
        bit_d = (cnt_q == CNT_LAST);
        bnd_c = (cnt_q == CNT_LAST);
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
    end

    // The adding edge still uses inc_q; the new value takes over from the next edge.
    apply_c = bnd_c | resync_in | ~en_in;

    if (inc_load_in) begin
      if (apply_c) begin
        inc_d  = inc_in;
        pend_d = 1'b0;
      end else begin
        pend_val_d = inc_in;
        pend_d     = 1'b1;
      end
    end else if (pend_q && apply_c) begin
      inc_d  = pend_val_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      inc_q      <= INC_RST;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      os_q       <= 1'b0;
      mid_q      <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      inc_q      <= inc_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      os_q       <= os_d;
      mid_q      <= mid_d;
      bit_q      <= bit_d;
    end
  end

  assign pending_out  = pend_q;
  assign os_tick_out  = os_q;
  assign mid_tick_out = mid_q;
  assign bit_tick_out = bit_q;

endmodule

// File: doc/baud_tick_frac.md
# baud_tick_frac

Parametrised fractional baud-tick generator for the UART TX/RX paths. A phase accumulator produces an oversample tick, a bit tick and a mid-bit sample tick at any baud rate, with bounded long-run rate error. The baud increment is reprogrammable at runtime and takes effect only on a bit boundary. A resync input realigns phase to an RX start-bit edge. It replaces the fixed integer-divide oversample tick in the UART front end.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency.
- `BAUD`, 115_200, reset baud rate.
- `OVERSAMPLE`, 8, oversample ticks per bit; even, ≥2.
- `ACC_W`, 24, accumulator and increment width.
- `DEFAULT_INC`, round(BAUD·OVERSAMPLE·2^ACC_W / CLK_HZ) (=154619 at defaults), reset increment.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; asynchronous, active-high.
- `en_in`  in  1  advance accumulator when high.
- `resync_in`  in  1  one-cycle pulse; zero phase (RX start-bit detect).
- `inc_in`  in  ACC_W  new increment value.
- `inc_load_in`  in  1  one-cycle pulse; capture `inc_in`.
- `pending_out`  out  1  captured increment not yet applied.
- `os_tick_out`  out  1  one-cycle oversample tick.
- `mid_tick_out`  out  1  one-cycle mid-bit tick.
- `bit_tick_out`  out  1  one-cycle end-of-bit tick.

## Operation
- State: `acc` (ACC_W), `os_cnt` (0..OVERSAMPLE-1), `inc` (ACC_W), `pend_val` (ACC_W), `pend` (1).
- Per enabled edge: {carry, acc} <= acc + inc. The sum is ACC_W+1 bits, and acc keeps the low ACC_W bits (natural wrap).
- carry=1 → os_cnt increments, wrapping OVERSAMPLE-1 → 0.
- Tick outputs are registered, each high for exactly one cycle after the edge on which it is set:
  - `os_tick_out` <= carry.
  - `mid_tick_out` <= carry && os_cnt == OVERSAMPLE/2-1.
  - `bit_tick_out` <= carry && os_cnt == OVERSAMPLE-1.
- A bit boundary is any edge that sets `bit_tick_out`.
- Average os tick rate = CLK_HZ·inc/2^ACC_W. Tick spacing is ⌊2^ACC_W/inc⌋ or ⌈2^ACC_W/inc⌉ cycles.
- inc = 0 is legal: no carries, no ticks, acc frozen.
- `en_in`=0: acc and os_cnt hold, all tick outputs 0 the next cycle.
- Increment load:
  - `inc_load_in` → pend_val <= inc_in, pend <= 1. A second load before apply overwrites pend_val.
- Increment apply: inc <= pend_val, pend <= 0, on the first edge where any of these hold:
  - (a) bit boundary;
  - (b) `resync_in`=1;
  - (c) `en_in`=0.
  - The edge that applies the new increment still uses the old increment for its own addition.
- Load coinciding with an apply edge: inc <= inc_in directly, pend stays/becomes 0.
- `resync_in` (priority over en_in advance): acc <= 0, os_cnt <= 0, all tick outputs <= 0. The next enabled edge starts a fresh bit.
- `pending_out` = pend (registered).

## Timing
- Reset (async assert, any time, including mid-bit):
  - acc = 0, os_cnt = 0, inc = DEFAULT_INC, pend_val = 0, pend = 0.
  - All outputs 0 immediately.
- First tick after reset release or resync with en_in=1: `os_tick_out` high following the N-th enabled edge, where N = ⌈2^ACC_W/inc⌉.
- Latency: carry edge → tick output visible that same edge (registered, one cycle wide). No combinational path from inputs to outputs.
- `bit_tick_out` and `os_tick_out` are coincident on the last oversample of each bit.
- `mid_tick_out` is coincident with the (OVERSAMPLE/2)-th `os_tick_out` of each bit.
- Simultaneous resync and load: resync applies; the increment becomes inc_in immediately.
- Simultaneous resync and en_in=0: resync still zeroes state.

## Test plan
- Defaults, hold en_in=1 for 10 ms → 9216 ±1 `os_tick_out` and 1152 ±1 `bit_tick_out`. Spacing is 108 or 109 cycles.
- ACC_W=8, OVERSAMPLE=4, DEFAULT_INC=64, reset release, en_in=1 → `os_tick_out` after edges 4, 8, 12, 16. `mid_tick_out` after edge 8. `bit_tick_out` after edge 16, then every 16.
- Same config, inc 96 via load → after the next bit boundary, ticks 3 per 8 cycles with spacing pattern 3,3,2. `pending_out` is 1 from the load until that boundary.
- Two loads (32 then 128) within one bit → only 128 is applied, at the boundary; 32 is never used.
- `resync_in` mid-bit (os_cnt=2, acc=100) → next cycle all ticks 0. First `os_tick_out` is 4 edges later, and `bit_tick_out` 16 edges later.
- `rst_in` asserted mid-tick between clock edges → outputs drop to 0 without a clock edge. After release, inc=DEFAULT_INC and `pending_out`=0.
